// File: rtl/pcd8544_spi_tx_if.sv
// Byte handshake between the LCD sequencer (master) and the PCD8544 SPI
// transmitter (slave): one byte plus a command/data flag per transfer.
interface pcd8544_spi_tx_if;
  logic [7:0]  data_in;
  logic        start;
  logic        command;
  logic [15:0] div_factor;
  logic        busy;
  logic        avail;

  modport master (
    output data_in, start, command, div_factor,
    input  busy, avail
  );

  modport slave (
    input  data_in, start, command, div_factor,
    output busy, avail
  );
endinterface

// File: rtl/pcd8544_spi_tx.sv
// Byte-level SPI transmitter for the PCD8544 (Nokia 5110) LCD.
// Generates the LCD hardware reset pulse after system reset, then serialises
// bytes MSB-first on mosi/sclk with sce/dc framing, pulsing avail per byte.
module pcd8544_spi_tx #(
  parameter int RST_LOW  = 16,
  parameter int RST_WAIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  pcd8544_spi_tx_if.slave         bus,
  output logic                    mosi,
  output logic                    sclk,
  output logic                    sce,
  output logic                    dc,
  output logic                    rst
);

  typedef enum logic [2:0] {
    LCD_RST,
    LCD_WAIT,
    IDLE,
    LOAD,
    SHIFT_LO,
    SHIFT_HI,
    DONE,
    GAP
  } state_t;

  localparam logic [15:0] RST_LOW_LAST  = 16'(RST_LOW - 1);
  localparam logic [15:0] RST_WAIT_LAST = 16'(RST_WAIT - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [15:0] half_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        cnt_clr;
  logic        load;
  logic        shift;

  // A divider of zero would stall the shifter, so it is clamped to one.
  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LCD_RST;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    unique case (state)
      LCD_RST: begin
        if (cnt == RST_LOW_LAST) begin
          state_next = LCD_WAIT;
          cnt_clr    = 1'b1;
        end
      end
      LCD_WAIT: begin
        if (cnt == RST_WAIT_LAST) begin
          state_next = IDLE;
          cnt_clr    = 1'b1;
        end
      end
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        load       = 1'b1;
        cnt_clr    = 1'b1;
        state_next = SHIFT_LO;
      end
      SHIFT_LO: begin
        if (cnt == half_n - 16'd1) begin
          state_next = SHIFT_HI;
          cnt_clr    = 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt == half_n - 16'd1) begin
          cnt_clr = 1'b1;
          if (bit_cnt == 3'd0) begin
            state_next = DONE;
          end else begin
            shift      = 1'b1;
            state_next = SHIFT_LO;
          end
        end
      end
      DONE: begin
        state_next = bus.start ? GAP : IDLE;
      end
      GAP: begin
        state_next = LOAD;
      end
      default: begin
        state_next = LCD_RST;
      end
    endcase
  end

  // Shared cycle counter for the reset phases and the sclk half-periods.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      cnt <= 16'd0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  // Byte capture at LOAD and MSB-first shifting after each sclk high phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg <= 8'd0;
      dc        <= 1'b0;
      bit_cnt   <= 3'd0;
    end else if (load) begin
      shift_reg <= bus.data_in;
      dc        <= bus.command;
      bit_cnt   <= 3'd7;
      half_n    <= clamp_div(bus.div_factor);
    end else if (shift) begin
      shift_reg <= {shift_reg[6:0], 1'b0};
      bit_cnt   <= bit_cnt - 3'd1;
    end
  end

  // Outputs registered from the next state so the LCD pins never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk      <= 1'b0;
      sce       <= 1'b1;
      rst       <= 1'b0;
      bus.busy  <= 1'b1;
      bus.avail <= 1'b0;
    end else begin
      sclk      <= (state_next == SHIFT_HI);
      sce       <= !((state_next == LOAD) || (state_next == SHIFT_LO) ||
                     (state_next == SHIFT_HI) || (state_next == DONE) ||
                     (state_next == GAP));
      rst       <= (state_next != LCD_RST);
      bus.busy  <= (state_next != IDLE);
      bus.avail <= (state_next == DONE);
    end
  end

  assign mosi = shift_reg[7];

endmodule

// File: tb/tb_pcd8544_spi_tx.sv
// Directed bench for pcd8544_spi_tx: LCD reset timing, single and
// back-to-back bytes, divider clamp, mid-byte reset and mid-byte start drop.
module tb_pcd8544_spi_tx;

  logic clk = 1'b0;
  logic reset;
  logic mosi, sclk, sce, dc, rst;

  pcd8544_spi_tx_if bus ();

  pcd8544_spi_tx #(.RST_LOW(16), .RST_WAIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .mosi  (mosi),
    .sclk  (sclk),
    .sce   (sce),
    .dc    (dc),
    .rst   (rst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // LCD-side observer state, updated once per falling clock edge in tick()
  int         cyc = 0;
  logic       prev_sclk = 1'b0;
  logic       prev_mosi = 1'b0;
  logic       prev_avail = 1'b0;
  logic [7:0] rx_sr = 8'd0;
  int         rx_bits = 0;
  logic [7:0] rx_q[$];
  int         avail_cyc[$];
  int         avail_cnt = 0;
  int         avail_dbl = 0;
  int         mosi_viol = 0;
  int         dc_bad = 0;
  int         gap_bad = 0;
  int         last_rise = 0;
  int         exp_gap = 4;
  logic       exp_dc = 1'b0;
  logic       track_sce = 1'b0;
  int         sce_hi = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      if (rx_bits != 0 && (cyc - last_rise) != exp_gap) gap_bad++;
      last_rise = cyc;
      if (dc !== exp_dc) dc_bad++;
      rx_sr = {rx_sr[6:0], mosi};
      rx_bits++;
      if (rx_bits == 8) begin
        rx_q.push_back(rx_sr);
        rx_bits = 0;
      end
    end
    if (sclk === 1'b1 && prev_sclk === 1'b1 && mosi !== prev_mosi) mosi_viol++;
    if (bus.avail === 1'b1) begin
      avail_cnt++;
      avail_cyc.push_back(cyc);
      if (prev_avail === 1'b1) avail_dbl++;
    end
    if (track_sce && sce === 1'b1) sce_hi++;
    prev_sclk  = sclk;
    prev_mosi  = mosi;
    prev_avail = bus.avail;
  endtask

  task automatic wait_avail(input string tag);
    for (int i = 0; i < 400; i++) begin
      tick();
      if (bus.avail === 1'b1) break;
    end
    chk({tag, "_avail_seen"}, 32'(bus.avail), 32'd1);
  endtask

  // Releases reset and measures the rst-low and wait phases in clk cycles.
  task automatic measure_reset(input string tag);
    int n_low;
    int n_wait;
    int bad;
    n_low  = 0;
    n_wait = 0;
    bad    = 0;
    reset  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rst !== 1'b0) break;
      n_low++;
      if (sce !== 1'b1 || sclk !== 1'b0 || bus.avail !== 1'b0) bad++;
      tick();
    end
    for (int i = 0; i < 100; i++) begin
      if (!(rst === 1'b1 && bus.busy === 1'b1)) break;
      n_wait++;
      if (sce !== 1'b1 || sclk !== 1'b0 || bus.avail !== 1'b0) bad++;
      tick();
    end
    chk({tag, "_rst_low_len"}, 32'(n_low), 32'd16);
    chk({tag, "_wait_len"}, 32'(n_wait), 32'd16);
    chk({tag, "_idle_lines"}, 32'(bad), 32'd0);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_rst"}, 32'(rst), 32'd1);
  endtask

  initial begin
    int base_av;
    int base_rx;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.data_in    = 8'h00;
    bus.command    = 1'b0;
    bus.div_factor = 16'd2;

    // ---- reset values and LCD reset sequence ----
    repeat (3) tick();
    chk("rst_mosi",  32'(mosi), 32'd0);
    chk("rst_sclk",  32'(sclk), 32'd0);
    chk("rst_sce",   32'(sce), 32'd1);
    chk("rst_dc",    32'(dc), 32'd0);
    chk("rst_rst",   32'(rst), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd1);
    chk("rst_avail", 32'(bus.avail), 32'd0);
    measure_reset("por");

    // ---- single byte 0x21, command, div 2 ----
    base_rx        = rx_q.size();
    base_av        = avail_cnt;
    exp_dc         = 1'b0;
    exp_gap        = 4;
    bus.start      = 1'b1;
    bus.data_in    = 8'h21;
    bus.command    = 1'b0;
    bus.div_factor = 16'd2;
    tick();
    chk("b21_load_sce",  32'(sce), 32'd0);
    chk("b21_load_busy", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    wait_avail("b21");
    tick();
    chk("b21_sce_after",  32'(sce), 32'd1);
    chk("b21_busy_after", 32'(bus.busy), 32'd0);
    chk("b21_nbytes",     32'(rx_q.size() - base_rx), 32'd1);
    chk("b21_byte",       32'(rx_q[$]), 32'h21);
    repeat (3) tick();
    chk("b21_avail_cnt",  32'(avail_cnt - base_av), 32'd1);

    // ---- back-to-back 0x21, 0x90, 0x20 ----
    base_rx     = rx_q.size();
    bus.start   = 1'b1;
    bus.data_in = 8'h21;
    wait_avail("bb1");
    track_sce = 1'b1;
    tick();
    bus.data_in = 8'h90;
    wait_avail("bb2");
    tick();
    bus.data_in = 8'h20;
    wait_avail("bb3");
    track_sce = 1'b0;
    bus.start = 1'b0;
    chk("bb_sce_low",  32'(sce_hi), 32'd0);
    chk("bb_period1",  32'(avail_cyc[$-1] - avail_cyc[$-2]), 32'd35);
    chk("bb_period2",  32'(avail_cyc[$] - avail_cyc[$-1]), 32'd35);
    chk("bb_nbytes",   32'(rx_q.size() - base_rx), 32'd3);
    chk("bb_byte0",    32'(rx_q[base_rx]), 32'h21);
    chk("bb_byte1",    32'(rx_q[base_rx + 1]), 32'h90);
    chk("bb_byte2",    32'(rx_q[base_rx + 2]), 32'h20);
    repeat (3) tick();

    // ---- data bytes, div 0 clamped to 1, mid-byte changes ignored ----
    base_rx        = rx_q.size();
    exp_dc         = 1'b1;
    exp_gap        = 2;
    bus.start      = 1'b1;
    bus.command    = 1'b1;
    bus.data_in    = 8'h00;
    bus.div_factor = 16'd0;
    tick();
    tick();
    bus.command    = 1'b0;
    bus.div_factor = 16'd5;
    repeat (3) tick();
    chk("d0_dc_held", 32'(dc), 32'd1);
    wait_avail("d0a");
    bus.command    = 1'b1;
    bus.div_factor = 16'd0;
    wait_avail("d0b");
    bus.start = 1'b0;
    chk("d0_period", 32'(avail_cyc[$] - avail_cyc[$-1]), 32'd19);
    chk("d0_nbytes", 32'(rx_q.size() - base_rx), 32'd2);
    chk("d0_byte",   32'(rx_q[$]), 32'h00);
    repeat (3) tick();

    // ---- reset during bit 4, start held through the LCD reset ----
    exp_dc         = 1'b0;
    exp_gap        = 4;
    bus.start      = 1'b1;
    bus.command    = 1'b0;
    bus.data_in    = 8'hFF;
    bus.div_factor = 16'd2;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (rx_bits == 4) break;
    end
    chk("ab_reached_bit4", 32'(rx_bits), 32'd4);
    reset          = 1'b1;
    bus.data_in    = 8'h3C;
    bus.div_factor = 16'd1;
    base_av        = avail_cnt;
    base_rx        = rx_q.size();
    tick();
    rx_bits = 0;
    rx_sr   = 8'd0;
    exp_gap = 2;
    chk("ab_sce",   32'(sce), 32'd1);
    chk("ab_sclk",  32'(sclk), 32'd0);
    chk("ab_rst",   32'(rst), 32'd0);
    chk("ab_avail", 32'(bus.avail), 32'd0);
    chk("ab_busy",  32'(bus.busy), 32'd1);
    chk("ab_mosi",  32'(mosi), 32'd0);
    measure_reset("ab");
    chk("ab_no_avail", 32'(avail_cnt - base_av), 32'd0);
    tick();
    bus.start = 1'b0;
    wait_avail("ab3c");
    chk("ab_nbytes", 32'(rx_q.size() - base_rx), 32'd1);
    chk("ab_byte",   32'(rx_q[$]), 32'h3C);
    repeat (3) tick();

    // ---- start dropped mid-byte, 0xA5 at div 3 ----
    base_rx        = rx_q.size();
    base_av        = avail_cnt;
    exp_gap        = 6;
    bus.start      = 1'b1;
    bus.data_in    = 8'hA5;
    bus.div_factor = 16'd3;
    repeat (10) tick();
    bus.start = 1'b0;
    wait_avail("a5");
    tick();
    chk("a5_sce_after",  32'(sce), 32'd1);
    chk("a5_busy_after", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    chk("a5_busy_idle",  32'(bus.busy), 32'd0);
    chk("a5_avail_cnt",  32'(avail_cnt - base_av), 32'd1);
    chk("a5_nbytes",     32'(rx_q.size() - base_rx), 32'd1);
    chk("a5_byte",       32'(rx_q[$]), 32'hA5);

    // ---- whole-run line discipline ----
    chk("mosi_stable_sclk_hi", 32'(mosi_viol), 32'd0);
    chk("avail_single_cycle",  32'(avail_dbl), 32'd0);
    chk("dc_at_rises",         32'(dc_bad), 32'd0);
    chk("sclk_rise_spacing",   32'(gap_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
